// File: rtl/serial_rx_pkg.sv
// Shared types and defaults for the serial word receiver: FSM state encoding,
// default parameter values and a pointer-width helper.
package serial_rx_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        STOP = 2'd2
    } rx_state_e;

    localparam int DEF_WIDTH      = 8;
    localparam int DEF_FIFO_DEPTH = 4;
    localparam int DEF_CNT_W      = 16;

    // Never narrower than one bit, so a depth or count of 1 still gets a real vector.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/serial_rx_fifo.sv
// Synchronous first-word-fall-through FIFO. Full/empty come from an occupancy
// counter one bit wider than the naturally wrapping pointers.
module serial_rx_fifo
    import serial_rx_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_FIFO_DEPTH,
    localparam int PTR_W = ptr_width(DEPTH),
    localparam int CNT_BITS = PTR_W + 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                push,
    input  logic [WIDTH-1:0]    push_data,
    input  logic                pop,
    output logic [WIDTH-1:0]    head,
    output logic                empty,
    output logic                full,
    output logic [CNT_BITS-1:0] count
);

    logic [WIDTH-1:0]    mem_q [DEPTH];
    logic [PTR_W-1:0]    rd_ptr_q;
    logic [PTR_W-1:0]    wr_ptr_q;
    logic [CNT_BITS-1:0] count_q;
    logic                push_ok;
    logic                pop_ok;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_BITS'(DEPTH));
    assign pop_ok  = pop & ~empty;
    // A pop in the same cycle frees the slot a full FIFO needs for the push.
    assign push_ok = push & (~full | pop_ok);
    assign head    = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CNT_BITS'(1);
                2'b01:   count_q <= count_q - CNT_BITS'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/serial_word_rx.sv
// Frames a one-bit-per-clock line (start, WIDTH data bits MSB-first, stop) into
// words, queues them in a FWFT FIFO and keeps sticky error flags plus a word count.
module serial_word_rx
    import serial_rx_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int CNT_W      = DEF_CNT_W,
    localparam int OCC_W     = ptr_width(FIFO_DEPTH) + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             y_in,
    output logic [WIDTH-1:0] word_out,
    output logic             word_valid,
    input  logic             word_ready,
    output logic             overflow,
    output logic             frame_err,
    input  logic             clear_flags,
    output logic [CNT_W-1:0] frame_count,
    output rx_state_e        fsm_state_o,
    output logic [OCC_W-1:0] fifo_count_o
);

    // Handshake: word_out is transferred on a clock edge where word_valid and
    // word_ready are both high; word_valid never depends on word_ready.

    localparam int BIT_W = ptr_width(WIDTH);

    rx_state_e        state_q, state_d;
    logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] hold_q;
    logic             overflow_q, overflow_d;
    logic             frame_err_q, frame_err_d;
    logic [CNT_W-1:0] frame_count_q, frame_count_d;

    logic             push_req;
    logic             frame_bad;
    logic             pop_fire;
    logic             push_accept;
    logic             drop_word;
    logic [WIDTH-1:0] fifo_head;
    logic             fifo_empty;
    logic             fifo_full;

    serial_rx_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push_req),
        .push_data (shift_q),
        .pop       (word_ready),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .count     (fifo_count_o)
    );

    assign word_valid  = ~fifo_empty;
    assign pop_fire    = word_valid & word_ready;
    assign push_accept = push_req & (~fifo_full | pop_fire);
    assign drop_word   = push_req & fifo_full & ~pop_fire;
    // Once the FIFO drains, keep presenting the last head rather than a stale slot.
    assign word_out    = word_valid ? fifo_head : hold_q;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        push_req  = 1'b0;
        frame_bad = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (y_in) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                end
            end
            DATA: begin
                shift_d   = {shift_q[WIDTH-2:0], y_in};
                bit_cnt_d = bit_cnt_q + BIT_W'(1);
                if (bit_cnt_q == BIT_W'(WIDTH - 1)) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                // A high stop bit is consumed here, never reused as a start bit.
                state_d = IDLE;
                if (y_in) begin
                    frame_bad = 1'b1;
                end else begin
                    push_req = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        overflow_d    = overflow_q;
        frame_err_d   = frame_err_q;
        frame_count_d = frame_count_q;
        if (clear_flags) begin
            overflow_d  = 1'b0;
            frame_err_d = 1'b0;
        end
        if (drop_word) begin
            overflow_d = 1'b1;
        end
        if (frame_bad) begin
            frame_err_d = 1'b1;
        end
        if (push_accept && (frame_count_q != '1)) begin
            frame_count_d = frame_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            hold_q        <= '0;
            overflow_q    <= 1'b0;
            frame_err_q   <= 1'b0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            overflow_q    <= overflow_d;
            frame_err_q   <= frame_err_d;
            frame_count_q <= frame_count_d;
            if (word_valid) begin
                hold_q <= fifo_head;
            end
        end
    end

    assign overflow    = overflow_q;
    assign frame_err   = frame_err_q;
    assign frame_count = frame_count_q;
    assign fsm_state_o = state_q;

endmodule

// File: tb/tb_serial_word_rx.sv
// Bench for serial_word_rx: directed frames plus random traffic, compared every
// cycle against a queue-based model of the receiver's observable behaviour.
module tb_serial_word_rx;
    import serial_rx_pkg::*;

    localparam int W = 8;
    localparam int D = 4;

    logic         clock;
    logic         reset;
    logic         y_in;
    logic         word_ready;
    logic         clear_flags;

    logic [W-1:0] word_out;
    logic         word_valid;
    logic         overflow;
    logic         frame_err;
    logic [15:0]  frame_count;
    rx_state_e    fsm_state;
    logic [2:0]   fifo_count;

    logic [W-1:0] s_word_out;
    logic         s_word_valid;
    logic         s_overflow;
    logic         s_frame_err;
    logic [3:0]   s_frame_count;
    rx_state_e    s_fsm_state;
    logic [2:0]   s_fifo_count;

    serial_word_rx dut (
        .clock        (clock),
        .reset        (reset),
        .y_in         (y_in),
        .word_out     (word_out),
        .word_valid   (word_valid),
        .word_ready   (word_ready),
        .overflow     (overflow),
        .frame_err    (frame_err),
        .clear_flags  (clear_flags),
        .frame_count  (frame_count),
        .fsm_state_o  (fsm_state),
        .fifo_count_o (fifo_count)
    );

    serial_word_rx #(.CNT_W(4)) dut_sat (
        .clock        (clock),
        .reset        (reset),
        .y_in         (y_in),
        .word_out     (s_word_out),
        .word_valid   (s_word_valid),
        .word_ready   (word_ready),
        .overflow     (s_overflow),
        .frame_err    (s_frame_err),
        .clear_flags  (clear_flags),
        .frame_count  (s_frame_count),
        .fsm_state_o  (s_fsm_state),
        .fifo_count_o (s_fifo_count)
    );

    // clock / reset
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // scoreboard and reference model
    logic [W-1:0] exp_q[$];
    logic [W-1:0] last_word;
    logic         exp_ovf;
    logic         exp_ferr;
    int unsigned  exp_cnt;
    int unsigned  exp_cnt_sat;
    int           n_tests;
    int           n_fail;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        last_word   = '0;
        exp_ovf     = 1'b0;
        exp_ferr    = 1'b0;
        exp_cnt     = 0;
        exp_cnt_sat = 0;
    endtask

    // ev: 0 = no frame end, 1 = good stop (push data), 2 = bad stop
    task automatic model_update(input logic rdy, input logic clr, input int ev,
                                input logic [W-1:0] data);
        logic pop;
        pop = rdy && (exp_q.size() > 0);
        if (exp_q.size() > 0) last_word = exp_q[0];
        if (clr) begin
            exp_ovf  = 1'b0;
            exp_ferr = 1'b0;
        end
        if (ev == 2) exp_ferr = 1'b1;
        if (pop) void'(exp_q.pop_front());
        if (ev == 1) begin
            if (exp_q.size() < D) begin
                exp_q.push_back(data);
                if (exp_cnt < 65535) exp_cnt++;
                if (exp_cnt_sat < 15) exp_cnt_sat++;
            end else begin
                exp_ovf = 1'b1;
            end
        end
    endtask

    task automatic check_outputs();
        check("word_valid", 32'(word_valid), 32'(exp_q.size() > 0));
        check("word_out", 32'(word_out), 32'((exp_q.size() > 0) ? exp_q[0] : last_word));
        check("overflow", 32'(overflow), 32'(exp_ovf));
        check("frame_err", 32'(frame_err), 32'(exp_ferr));
        check("frame_count", 32'(frame_count), exp_cnt);
        check("frame_count_sat", 32'(s_frame_count), exp_cnt_sat);
        check("occupancy", 32'(fifo_count), 32'(exp_q.size()));
    endtask

    // driver tasks
    task automatic step(input logic y, input logic rdy, input logic clr, input int ev,
                        input logic [W-1:0] data);
        @(negedge clock);
        check_outputs();
        y_in        = y;
        word_ready  = rdy;
        clear_flags = clr;
        model_update(rdy, clr, ev, data);
    endtask

    task automatic apply_reset();
        @(negedge clock);
        reset       = 1'b1;
        y_in        = 1'b0;
        word_ready  = 1'b0;
        clear_flags = 1'b0;
        model_reset();
        #1;
        check_outputs();
        check("state_after_reset", 32'(fsm_state), 32'(IDLE));
        @(negedge clock);
        reset = 1'b0;
    endtask

    // rmode: 0 ready low, 1 ready high, 2 random ready, 3 ready only on the stop cycle
    function automatic logic pick_ready(input int rmode, input logic at_stop);
        case (rmode)
            1:       return 1'b1;
            2:       return 1'($urandom_range(0, 1));
            3:       return at_stop;
            default: return 1'b0;
        endcase
    endfunction

    task automatic send_frame(input logic [W-1:0] data, input logic bad_stop,
                              input int rmode, input logic stop_clr);
        step(1'b1, pick_ready(rmode, 1'b0), 1'b0, 0, '0);
        for (int i = W - 1; i >= 0; i--) begin
            step(data[i], pick_ready(rmode, 1'b0), 1'b0, 0, '0);
        end
        step(bad_stop, pick_ready(rmode, 1'b1), stop_clr, bad_stop ? 2 : 1, data);
    endtask

    task automatic idle(input int n, input int rmode);
        for (int i = 0; i < n; i++) begin
            step(1'b0, pick_ready(rmode, 1'b0), 1'b0, 0, '0);
        end
    endtask

    initial begin
        n_tests     = 0;
        n_fail      = 0;
        reset       = 1'b1;
        y_in        = 1'b0;
        word_ready  = 1'b0;
        clear_flags = 1'b0;
        model_reset();

        // single frame, valid appears 10 cycles after the start bit
        apply_reset();
        send_frame(8'hA5, 1'b0, 0, 1'b0);
        idle(3, 0);
        check("first_word", 32'(word_out), 32'h0000_00A5);

        // five frames into a depth-4 FIFO, then drain
        apply_reset();
        for (int f = 1; f <= 5; f++) send_frame(W'(f), 1'b0, 0, 1'b0);
        idle(2, 0);
        check("five_frames_count", 32'(frame_count), 32'd4);
        idle(6, 1);

        // framing error, set-wins over clear, explicit clear, then a good frame
        send_frame(8'h3C, 1'b1, 0, 1'b1);
        idle(2, 0);
        step(1'b0, 1'b0, 1'b1, 0, '0);
        idle(1, 0);
        send_frame(8'h3C, 1'b0, 0, 1'b0);
        idle(3, 1);

        // full FIFO with a pop on the stop cycle accepts the new word
        apply_reset();
        send_frame(8'h11, 1'b0, 0, 1'b0);
        send_frame(8'h22, 1'b0, 0, 1'b0);
        send_frame(8'h33, 1'b0, 0, 1'b0);
        send_frame(8'h44, 1'b0, 0, 1'b0);
        send_frame(8'h77, 1'b0, 3, 1'b0);
        idle(2, 0);
        idle(6, 1);

        // reset in the middle of a frame, then a clean frame
        send_frame(8'h5A, 1'b0, 0, 1'b0);
        send_frame(8'hC3, 1'b0, 0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 0, '0);
        for (int i = 0; i < 4; i++) step(1'($urandom_range(0, 1)), 1'b0, 1'b0, 0, '0);
        apply_reset();
        send_frame(8'hFF, 1'b0, 0, 1'b0);
        idle(3, 1);

        // saturation of the 4-bit counter instance
        apply_reset();
        for (int f = 0; f < 17; f++) send_frame(W'($urandom_range(0, 255)), 1'b0, 1, 1'b0);
        idle(2, 1);
        check("sat_count", 32'(s_frame_count), 32'h0000_000F);
        check("main_count_17", 32'(frame_count), 32'd17);

        // random traffic
        apply_reset();
        for (int f = 0; f < 40; f++) begin
            send_frame(W'($urandom_range(0, 255)), ($urandom_range(0, 5) == 0), 2,
                       ($urandom_range(0, 7) == 0));
            for (int g = $urandom_range(0, 3); g > 0; g--) begin
                step(1'b0, 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0), 0, '0);
            end
        end
        idle(8, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
